// File: rtl/bank_isu_arb.sv
// Four-channel round-robin arbiter feeding a one-entry output stage for the bank issue queue.
// Per-channel credit counters are built only when BANK_ISU_ARB_CREDIT_EN is defined.
module bank_isu_arb #(
    parameter int CREDITS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  ch_req_valid_i,
    output logic [3:0]  ch_req_allowIn_o,
    input  logic [11:0] ch_req_rob_id_i,
    input  logic [7:0]  ch_req_opcode_i,
    input  logic [27:0] ch_req_set_way_offset_i,
    input  logic [31:0] ch_req_wbuffer_id_i,
    input  logic [15:0] ch_req_state_i,
    input  logic        rel_valid_i,
    input  logic [1:0]  rel_ch_id_i,
    output logic        iq_req_valid_o,
    input  logic        iq_req_allowIn_i,
    output logic [2:0]  iq_req_rob_id_o,
    output logic [1:0]  iq_req_ch_id_o,
    output logic [1:0]  iq_req_opcode_o,
    output logic [6:0]  iq_req_set_way_offset_o,
    output logic [7:0]  iq_req_wbuffer_id_o,
    output logic [1:0]  iq_req_cacheline_offset0_state_o,
    output logic [1:0]  iq_req_cacheline_offset1_state_o,
    output logic        credit_err_o
);

    logic [1:0] rr_ptr_q;
    logic [3:0] eligible;
    logic [3:0] grant;
    logic [1:0] win_id;
    logic [1:0] idx;
    logic       found;
    logic       stage_ready;

    assign stage_ready = !iq_req_valid_o || iq_req_allowIn_i;

`ifdef BANK_ISU_ARB_CREDIT_EN
    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0] credit_q [4];
    logic          rel_hit;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            eligible[k] = ch_req_valid_i[k] && (credit_q[k] != '0);
        end
    end

    // A same-cycle grant and release cancel out; a release on a full counter is an error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                credit_q[k] <= CW'(CREDITS);
            end
            credit_err_o <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                rel_hit = rel_valid_i && (rel_ch_id_i == 2'(k));
                if (grant[k] && !rel_hit) begin
                    credit_q[k] <= credit_q[k] - 1'b1;
                end else if (rel_hit && !grant[k]) begin
                    if (credit_q[k] == CW'(CREDITS)) begin
                        credit_err_o <= 1'b1;
                    end else begin
                        credit_q[k] <= credit_q[k] + 1'b1;
                    end
                end
            end
        end
    end
`else
    logic [6:0] unused_cfg;

    assign unused_cfg   = {4'(CREDITS), rel_valid_i, rel_ch_id_i};
    assign eligible     = ch_req_valid_i;
    assign credit_err_o = 1'b0;
`endif

    // Search upward from the pointer; the first eligible channel wins if the stage can take it.
    always_comb begin
        found  = 1'b0;
        win_id = 2'd0;
        idx    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
        grant = (found && stage_ready) ? (4'b0001 << win_id) : 4'b0000;
    end

    assign ch_req_allowIn_o = grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q                         <= 2'd0;
            iq_req_valid_o                   <= 1'b0;
            iq_req_rob_id_o                  <= '0;
            iq_req_ch_id_o                   <= '0;
            iq_req_opcode_o                  <= '0;
            iq_req_set_way_offset_o          <= '0;
            iq_req_wbuffer_id_o              <= '0;
            iq_req_cacheline_offset0_state_o <= '0;
            iq_req_cacheline_offset1_state_o <= '0;
        end else if (|grant) begin
            rr_ptr_q                         <= win_id + 2'd1;
            iq_req_valid_o                   <= 1'b1;
            iq_req_rob_id_o                  <= ch_req_rob_id_i[3*win_id +: 3];
            iq_req_ch_id_o                   <= win_id;
            iq_req_opcode_o                  <= ch_req_opcode_i[2*win_id +: 2];
            iq_req_set_way_offset_o          <= ch_req_set_way_offset_i[7*win_id +: 7];
            iq_req_wbuffer_id_o              <= ch_req_wbuffer_id_i[8*win_id +: 8];
            iq_req_cacheline_offset0_state_o <= ch_req_state_i[4*win_id +: 2];
            iq_req_cacheline_offset1_state_o <= ch_req_state_i[4*win_id+2 +: 2];
        end else if (iq_req_allowIn_i) begin
            iq_req_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bank_isu_arb.sv
// Directed self-checking bench for bank_isu_arb; credit scenarios run when BANK_ISU_ARB_CREDIT_EN is defined.
module tb_bank_isu_arb;

`ifdef BANK_ISU_ARB_CREDIT_EN
    localparam int CREDITS = 2;
`else
    localparam int CREDITS = 4;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  ch_req_valid_i;
    logic [3:0]  ch_req_allowIn_o;
    logic [11:0] ch_req_rob_id_i;
    logic [7:0]  ch_req_opcode_i;
    logic [27:0] ch_req_set_way_offset_i;
    logic [31:0] ch_req_wbuffer_id_i;
    logic [15:0] ch_req_state_i;
    logic        rel_valid_i;
    logic [1:0]  rel_ch_id_i;
    logic        iq_req_valid_o;
    logic        iq_req_allowIn_i;
    logic [2:0]  iq_req_rob_id_o;
    logic [1:0]  iq_req_ch_id_o;
    logic [1:0]  iq_req_opcode_o;
    logic [6:0]  iq_req_set_way_offset_o;
    logic [7:0]  iq_req_wbuffer_id_o;
    logic [1:0]  iq_req_cacheline_offset0_state_o;
    logic [1:0]  iq_req_cacheline_offset1_state_o;
    logic        credit_err_o;

    int assertCount = 0;
    int failCount   = 0;

    bank_isu_arb #(.CREDITS(CREDITS)) dut (
        .clk_i                            (clk_i),
        .rst_i                            (rst_i),
        .ch_req_valid_i                   (ch_req_valid_i),
        .ch_req_allowIn_o                 (ch_req_allowIn_o),
        .ch_req_rob_id_i                  (ch_req_rob_id_i),
        .ch_req_opcode_i                  (ch_req_opcode_i),
        .ch_req_set_way_offset_i          (ch_req_set_way_offset_i),
        .ch_req_wbuffer_id_i              (ch_req_wbuffer_id_i),
        .ch_req_state_i                   (ch_req_state_i),
        .rel_valid_i                      (rel_valid_i),
        .rel_ch_id_i                      (rel_ch_id_i),
        .iq_req_valid_o                   (iq_req_valid_o),
        .iq_req_allowIn_i                 (iq_req_allowIn_i),
        .iq_req_rob_id_o                  (iq_req_rob_id_o),
        .iq_req_ch_id_o                   (iq_req_ch_id_o),
        .iq_req_opcode_o                  (iq_req_opcode_o),
        .iq_req_set_way_offset_o          (iq_req_set_way_offset_o),
        .iq_req_wbuffer_id_o              (iq_req_wbuffer_id_o),
        .iq_req_cacheline_offset0_state_o (iq_req_cacheline_offset0_state_o),
        .iq_req_cacheline_offset1_state_o (iq_req_cacheline_offset1_state_o),
        .credit_err_o                     (credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic [3:0] valid, input logic allowIn,
                                 input logic relValid, input logic [1:0] relCh);
        ch_req_valid_i   = valid;
        iq_req_allowIn_i = allowIn;
        rel_valid_i      = relValid;
        rel_ch_id_i      = relCh;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land just after the following falling edge.
    task automatic nextCycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        // Channel payloads: ch2 carries rob_id 5 and wbuffer_id 0xA3.
        ch_req_rob_id_i         = {3'd6, 3'd5, 3'd3, 3'd1};
        ch_req_opcode_i         = {2'd3, 2'd2, 2'd1, 2'd0};
        ch_req_set_way_offset_i = {7'h33, 7'h22, 7'h11, 7'h05};
        ch_req_wbuffer_id_i     = {8'h3C, 8'hA3, 8'h5A, 8'h11};
        ch_req_state_i          = {4'hD, 4'h6, 4'h9, 4'h2};
        rst_i = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);

        checkOutput("reset_valid", 32'(iq_req_valid_o), 32'd0);
        checkOutput("reset_allowIn", 32'(ch_req_allowIn_o), 32'd0);
        checkOutput("reset_rob_id", 32'(iq_req_rob_id_o), 32'd0);
        checkOutput("reset_wbuffer", 32'(iq_req_wbuffer_id_o), 32'd0);
        checkOutput("reset_credit_err", 32'(credit_err_o), 32'd0);

        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Single request on ch2.
        applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0);
        checkOutput("single_grant", 32'(ch_req_allowIn_o), 32'b0100);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        checkOutput("single_valid", 32'(iq_req_valid_o), 32'd1);
        checkOutput("single_ch_id", 32'(iq_req_ch_id_o), 32'd2);
        checkOutput("single_rob_id", 32'(iq_req_rob_id_o), 32'd5);
        checkOutput("single_wbuffer", 32'(iq_req_wbuffer_id_o), 32'hA3);
        checkOutput("single_opcode", 32'(iq_req_opcode_o), 32'd2);
        checkOutput("single_swo", 32'(iq_req_set_way_offset_o), 32'h22);
        checkOutput("single_off0_state", 32'(iq_req_cacheline_offset0_state_o), 32'd2);
        checkOutput("single_off1_state", 32'(iq_req_cacheline_offset1_state_o), 32'd1);
        // Pointer now 3: with everyone valid ch3 must win.
        applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("ptr_after_ch2", 32'(ch_req_allowIn_o), 32'b1000);
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        nextCycle();
        checkOutput("drain_no_refill", 32'(iq_req_valid_o), 32'd0);

        // Fresh reset, then rotation with all channels valid.
        rst_i = 1'b1;
        #1;
        rst_i = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("rot_grant_%0d", i), 32'(ch_req_allowIn_o), 32'(4'b0001 << (i % 4)));
            if (i > 0) begin
                checkOutput($sformatf("rot_valid_%0d", i), 32'(iq_req_valid_o), 32'd1);
                checkOutput($sformatf("rot_ch_id_%0d", i), 32'(iq_req_ch_id_o), 32'((i - 1) % 4));
            end
            nextCycle();
        end

        // Backpressure: stage holds ch3, ch1 and ch3 waiting.
        applyStimulus(4'b1010, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall_allowIn_%0d", i), 32'(ch_req_allowIn_o), 32'd0);
            checkOutput($sformatf("stall_ch_id_%0d", i), 32'(iq_req_ch_id_o), 32'd3);
            checkOutput($sformatf("stall_rob_id_%0d", i), 32'(iq_req_rob_id_o), 32'd6);
            nextCycle();
            #1;
        end
        applyStimulus(4'b1010, 1'b1, 1'b0, 2'd0);
        checkOutput("refill_grant", 32'(ch_req_allowIn_o), 32'b0010);
        nextCycle();
        applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0);
        checkOutput("refill_valid", 32'(iq_req_valid_o), 32'd1);
        checkOutput("refill_ch_id", 32'(iq_req_ch_id_o), 32'd1);
        checkOutput("refill_rob_id", 32'(iq_req_rob_id_o), 32'd3);

        // Mid-operation reset with pointer at 2 and a held request.
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(iq_req_valid_o), 32'd0);
        checkOutput("midrst_ch_id", 32'(iq_req_ch_id_o), 32'd0);
        rst_i = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0);
        checkOutput("midrst_ptr", 32'(ch_req_allowIn_o), 32'b0001);
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        nextCycle();

`ifdef BANK_ISU_ARB_CREDIT_EN
        // Credit exhaustion on ch0 with CREDITS=2.
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_grant_a", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_grant_b", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_empty_a", 32'(ch_req_allowIn_o), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0);
        checkOutput("cred_empty_b", 32'(ch_req_allowIn_o), 32'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_released", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_empty_c", 32'(ch_req_allowIn_o), 32'd0);
        checkOutput("cred_err_clear", 32'(credit_err_o), 32'd0);

        // Over-release on full ch1 sets a sticky error.
        applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_err_set", 32'(credit_err_o), 32'd1);
        nextCycle();
        checkOutput("cred_err_sticky", 32'(credit_err_o), 32'd1);

        // Bring ch0 to credit 1, then grant and release together.
        applyStimulus(4'b0000, 1'b1, 1'b1, 2'd0);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0);
        checkOutput("simul_grant", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("simul_regrant", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("simul_empty", 32'(ch_req_allowIn_o), 32'd0);

        // Reset restores every credit.
        rst_i = 1'b1;
        #1;
        checkOutput("cred_rst_err", 32'(credit_err_o), 32'd0);
        rst_i = 1'b0;
        applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
        checkOutput("cred_rst_grant", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
`else
        // Without credits the release port is ignored and the error flag stays low.
        applyStimulus(4'b0001, 1'b1, 1'b1, 2'd1);
        checkOutput("nocred_grant", 32'(ch_req_allowIn_o), 32'b0001);
        nextCycle();
        checkOutput("nocred_err", 32'(credit_err_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0);
            checkOutput($sformatf("nocred_repeat_%0d", i), 32'(ch_req_allowIn_o), 32'b0001);
            nextCycle();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bank_isu_arb.md
# bank_isu_arb

Four-channel round-robin arbiter that sits in front of the bank issue queue. It collects requests from up to four requester channels, selects one per cycle, and registers the winner into a one-entry output stage. That stage drives the issue queue's valid/allowIn write port. The winning channel number is stamped onto the outgoing request as its channel ID, and optional per-channel credit counters cap how many entries each channel holds in the queue.

## Interface
- `CREDITS`, default 4: maximum outstanding entries per channel (1..15). Used only when credits are compiled in.
- `clk_i`  in  1  clock; all flops are rising-edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `ch_req_valid_i`  in  4  per-channel request valid; bit k is channel k.
- `ch_req_allowIn_o`  out  4  per-channel accept, one-hot or zero.
- `ch_req_rob_id_i`  in  12  3 bits per channel, channel k at [3k+2:3k].
- `ch_req_opcode_i`  in  8  2 bits per channel.
- `ch_req_set_way_offset_i`  in  28  7 bits per channel.
- `ch_req_wbuffer_id_i`  in  32  8 bits per channel.
- `ch_req_state_i`  in  16  4 bits per channel, laid out as {offset1_state, offset0_state}.
- `rel_valid_i`  in  1  credit release pulse, raised when the queue retires an entry.
- `rel_ch_id_i`  in  2  channel being released.
- `iq_req_valid_o`  out  1  output stage holds a request.
- `iq_req_allowIn_i`  in  1  issue queue can accept.
- `iq_req_rob_id_o` (3), `iq_req_ch_id_o` (2), `iq_req_opcode_o` (2), `iq_req_set_way_offset_o` (7), `iq_req_wbuffer_id_o` (8), `iq_req_cacheline_offset0_state_o` (2), `iq_req_cacheline_offset1_state_o` (2)  out  registered payload.
- `credit_err_o`  out  1  sticky flag: a release arrived for a channel whose credits were already full.

## Operation
- **Transfer rule.** A transfer happens on any valid/allowIn pair when both are high in the same cycle.
- **Output stage readiness.** The output stage can take a new request when `iq_req_valid_o`=0, or when `iq_req_allowIn_i`=1 in the same cycle (drain and refill together).
- **Eligibility.** Channel k is eligible when `ch_req_valid_i[k]`=1 and it has credit (credit_Q[k]≠0; see Configuration).
- **Grant.**
  - Granting requires the output stage to be ready.
  - The winner is the first eligible channel searching upward from `rr_ptr_Q` (2-bit, wrapping from 3 to 0).
  - `ch_req_allowIn_o` is one-hot on the winner and zero otherwise. It depends combinationally on the valids, the credits, `rr_ptr_Q`, `iq_req_valid_o` and `iq_req_allowIn_i`.
- **On a grant to channel k:**
  - `rr_ptr_Q` <= k+1 (mod 4).
  - The output stage loads channel k's payload, with `iq_req_ch_id_o`=k.
  - `iq_req_valid_o` <= 1.
- **Pointer hold.** With no grant, `rr_ptr_Q` holds.
- **Drain without refill.** If the output drains and nothing is granted, `iq_req_valid_o` <= 0. The payload registers hold their values but are don't-care.
- **Stall.** While `iq_req_valid_o`=1 and `iq_req_allowIn_i`=0, the payload is held stable and all `ch_req_allowIn_o` are 0.

## Timing
- **Latency.** A grant in cycle N presents the request at the queue from cycle N+1.
- **Throughput.** One request per cycle with the queue always ready.
- **Reset values.**
  - Registers: `rr_ptr_Q`=0, `iq_req_valid_o`=0, payload outputs 0, every credit_Q=CREDITS, `credit_err_o`=0.
  - `ch_req_allowIn_o` is combinational and evaluates to 0 whenever no channel is eligible.
- **Reset mid-operation.** Asserting `rst_i` clears the output stage asynchronously; a held request is dropped.
- **Fairness.** With all four channels continuously valid, grants rotate 0,1,2,3,0… and no channel waits more than 3 grants.
- **Payload stability.** Request payloads must be stable while their valid is high. The arbiter samples them only on a grant.

## Configuration
- `BANK_ISU_ARB_CREDIT_EN` defined:
  - Each channel has a counter, width $clog2(CREDITS+1), reset to CREDITS.
  - A grant decrements it and a release increments it; a grant and a release on the same channel in the same cycle leave it unchanged.
  - A channel at 0 is ineligible.
  - A release on a counter already at CREDITS (with no same-cycle grant on that channel) leaves the count unchanged and sets `credit_err_o`, which clears only on reset.
- `BANK_ISU_ARB_CREDIT_EN` not defined:
  - No counters are built, and every valid channel is eligible.
  - `rel_valid_i` and `rel_ch_id_i` are ignored, and `credit_err_o` is tied to 0.

## Test plan
- **Reset and single request.** Reset, then ch2 valid alone with rob_id=5, wbuffer_id=0xA3, queue ready → `ch_req_allowIn_o`=0100. Next cycle `iq_req_valid_o`=1, `iq_req_ch_id_o`=2, `iq_req_rob_id_o`=5, `iq_req_wbuffer_id_o`=0xA3; `rr_ptr_Q`=3.
- **Round-robin rotation.** All four channels valid for 8 cycles with the queue ready → grant order 0,1,2,3,0,1,2,3 and `iq_req_valid_o` continuously high from cycle 1.
- **Backpressure.**
  - Output stage full with `iq_req_allowIn_i`=0 for 5 cycles, ch1 and ch3 valid → `ch_req_allowIn_o`=0000 and the payload is unchanged.
  - On the first cycle with `iq_req_allowIn_i`=1, the stage drains and refills in the same cycle with the next round-robin winner.
- **Credit exhaustion (macro on, CREDITS=2).**
  - ch0 always valid, no releases → ch0 gets two grants and is then never granted.
  - A `rel_valid_i` pulse with `rel_ch_id_i`=0 → exactly one more grant to ch0.
  - A release to ch1 while it is at 2 → `credit_err_o`=1, which stays high.
- **Simultaneous grant and release (macro on).** ch0 at credit 1 is granted in the same cycle as a release for ch0 → credit stays 1, and ch0 is eligible and granted again the next cycle.
- **Mid-operation reset.** `rst_i` pulsed while `iq_req_valid_o`=1 and `rr_ptr_Q`=2 → `iq_req_valid_o`=0 immediately, `rr_ptr_Q`=0, and all credits back to CREDITS.
